fetch_stage: RTL and testbench

- Instruction-fetch stage of the 8-bit RISC pipeline.
- Holds the program counter and drives the instruction-memory address.
- Loads the FE/DE pipeline register, which feeds the controller's FEDEinput and the decode datapath.
- Resolves branches sitting in FE/DE using the Z/N flags from the controller; handles stall, flush-on-branch and halt.

---
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 8-bit RISC pipeline: owns the PC, drives imem,
// loads the FE/DE register and resolves branches held in FE/DE using the Z/N flags.
module fetch_stage #(
   parameter int              PC_W      = 8,
   parameter logic [PC_W-1:0] RESET_PC  = 8'h00,
   parameter logic [15:0]     NOP_WORD  = 16'h0000,
   parameter logic [15:0]     HALT_WORD = 16'h0FFF
) (
   input  logic              clk,
   input  logic              reset_input,
   input  logic              stall,
   input  logic              Z_input,
   input  logic              N_input,
   input  logic [15:0]       imem_data,
   output logic [PC_W-1:0]   imem_addr,
   output logic [PC_W+15:0]  FEDE_output,
   output logic [PC_W-1:0]   pc_out,
   output logic              branch_taken,
   output logic              halted
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W+15:0]  fede_q, fede_d;
   logic              halted_q, halted_d;
   logic [3:0]        br_op;
   logic [PC_W-1:0]   br_target;
   logic              cond_met;
   logic              take;

   assign br_op     = fede_q[15:12];
   assign br_target = fede_q[PC_W-1:0];

   // Branch condition decode on the instruction currently sitting in FE/DE.
   always_comb begin
      cond_met = 1'b0;
      case (br_op)
         4'b1001: cond_met = 1'b1;
         4'b1010: cond_met = Z_input;
         4'b1011: cond_met = N_input;
         4'b1100: cond_met = !Z_input;
         default: cond_met = 1'b0;
      endcase
   end

   assign take = (state_q == RUN) && !stall && cond_met;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      fede_d  = fede_q;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (!stall) begin
               if (cond_met) begin
                  // Redirect and squash the wrong-path fetch with a bubble.
                  pc_d   = br_target;
                  fede_d = {pc_q, NOP_WORD};
               end else if (fede_q[15:0] == HALT_WORD) begin
                  state_d = HALT;
                  fede_d  = {pc_q, NOP_WORD};
               end else begin
                  fede_d = {pc_q, imem_data};
                  pc_d   = pc_q + PC_W'(1);
               end
            end
         end
         HALT: fede_d = {pc_q, NOP_WORD};
         default: state_d = BOOT;
      endcase
      halted_d = (state_d == HALT);
   end

   always_ff @(posedge clk or negedge reset_input) begin
      if (!reset_input) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         fede_q   <= {RESET_PC, NOP_WORD};
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         fede_q   <= fede_d;
         halted_q <= halted_d;
      end
   end

   assign imem_addr    = pc_q;
   assign pc_out       = pc_q;
   assign FEDE_output  = fede_q;
   assign branch_taken = take;
   assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus
// randomized programs checked every cycle against an instruction-level model.
module tb_fetch_stage;

   logic        clk;
   logic        reset_input;
   logic        stall;
   logic        Z_input;
   logic        N_input;
   logic [15:0] imem_data;
   logic [7:0]  imem_addr;
   logic [23:0] FEDE_output;
   logic [7:0]  pc_out;
   logic        branch_taken;
   logic        halted;

   logic [15:0] mem [256];
   int          checks = 0;
   int          errors = 0;
   bit          check_en = 0;

   // Model: architectural view of fetch (phase 0 = boot, 1 = running, 2 = halted).
   logic [7:0]  m_pc   = 8'h00;
   logic [23:0] m_fede = 24'h000000;
   int          m_st   = 0;

   fetch_stage dut (
      .clk          (clk),
      .reset_input  (reset_input),
      .stall        (stall),
      .Z_input      (Z_input),
      .N_input      (N_input),
      .imem_data    (imem_data),
      .imem_addr    (imem_addr),
      .FEDE_output  (FEDE_output),
      .pc_out       (pc_out),
      .branch_taken (branch_taken),
      .halted       (halted)
   );

   assign imem_data = mem[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_taken();
      if (m_st != 1 || stall) return 1'b0;
      case (m_fede[15:12])
         4'd9:    return 1'b1;
         4'd10:   return Z_input;
         4'd11:   return N_input;
         4'd12:   return !Z_input;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_step();
      logic [7:0] tgt;
      if (m_st == 0) begin
         m_st = 1;
      end else if (m_st == 1 && !stall) begin
         if (m_taken()) begin
            tgt    = m_fede[7:0];
            m_fede = {m_pc, 16'h0000};
            m_pc   = tgt;
         end else if (m_fede[15:0] == 16'h0FFF) begin
            m_st   = 2;
            m_fede = {m_pc, 16'h0000};
         end else begin
            m_fede = {m_pc, mem[m_pc]};
            m_pc   = m_pc + 8'd1;
         end
      end
   endtask

   always @(negedge reset_input) begin
      m_pc   = 8'h00;
      m_fede = 24'h000000;
      m_st   = 0;
   end

   always @(posedge clk) begin
      if (reset_input === 1'b1) model_step();
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (check_en) begin
         check("cyc_pc_out", 32'(pc_out), 32'(m_pc));
         check("cyc_imem_addr", 32'(imem_addr), 32'(m_pc));
         check("cyc_fede", 32'(FEDE_output), 32'(m_fede));
         check("cyc_halted", 32'(halted), 32'(m_st == 2));
         check("cyc_branch_taken", 32'(branch_taken), 32'(m_taken()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_reset();
      @(posedge clk);
      #1;
      reset_input = 1'b0;
      stall       = 1'b0;
      Z_input     = 1'b0;
      N_input     = 1'b0;
      #1;
   endtask

   task automatic end_reset();
      @(posedge clk);
      #1;
      reset_input = 1'b1;
   endtask

   task automatic fill_mem(input logic [15:0] word);
      for (int i = 0; i < 256; i++) mem[i] = word;
   endtask

   task automatic fill_random();
      logic [3:0] op;
      int r;
      for (int i = 0; i < 256; i++) begin
         r = $urandom_range(0, 99);
         if (r < 1) begin
            mem[i] = 16'h0FFF;
         end else if (r < 35) begin
            op = 4'(9 + $urandom_range(0, 3));
            mem[i] = {op, 4'($urandom), 8'($urandom)};
         end else begin
            op = 4'($urandom_range(0, 11));
            if (op >= 4'd9) op = op + 4'd4;
            mem[i] = {op, 12'($urandom)};
         end
      end
   endtask

   task automatic run_branch(input logic [3:0] op, input logic z, input logic n,
                             input logic exp_taken, input string name);
      start_reset();
      fill_mem(16'h1111);
      mem[4] = {op, 12'h020};
      end_reset();
      repeat (6) step();
      check({name, "_fede_in"}, 32'(FEDE_output), 32'({8'h04, op, 12'h020}));
      Z_input = z;
      N_input = n;
      #1;
      check({name, "_taken"}, 32'(branch_taken), 32'(exp_taken));
      step();
      Z_input = 1'b0;
      N_input = 1'b0;
      check({name, "_pc"}, 32'(pc_out), exp_taken ? 32'h20 : 32'h06);
      check({name, "_fede"}, 32'(FEDE_output), exp_taken ? 32'h050000 : 32'h051111);
   endtask

   // Directed scenarios followed by randomized programs with random stalls, flags and resets.
   initial begin
      reset_input = 1'b0;
      stall       = 1'b0;
      Z_input     = 1'b0;
      N_input     = 1'b0;
      fill_mem(16'h0000);
      check_en = 1'b1;

      start_reset();
      check("rst_pc", 32'(pc_out), 32'h00);
      check("rst_fede", 32'(FEDE_output), 32'h000000);
      check("rst_halted", 32'(halted), 32'h0);
      mem[0] = 16'h1234;
      mem[1] = 16'h2345;
      end_reset();
      step();
      check("boot_fede", 32'(FEDE_output), 32'h000000);
      check("boot_pc", 32'(pc_out), 32'h00);
      step();
      check("fetch1_fede", 32'(FEDE_output), 32'h001234);
      check("fetch1_pc", 32'(pc_out), 32'h01);
      step();
      check("fetch2_fede", 32'(FEDE_output), 32'h012345);
      check("fetch2_pc", 32'(pc_out), 32'h02);

      start_reset();
      fill_mem(16'h1111);
      mem[0] = 16'h90FE;
      end_reset();
      repeat (3) step();
      check("wrap_redirect_pc", 32'(pc_out), 32'hFE);
      step();
      check("wrap_fede_fe", 32'(FEDE_output), 32'hFE1111);
      step();
      check("wrap_fede_ff", 32'(FEDE_output), 32'hFF1111);
      check("wrap_pc_00", 32'(pc_out), 32'h00);
      step();
      check("wrap_fede_00", 32'(FEDE_output), 32'h0090FE);
      check("wrap_pc_01", 32'(pc_out), 32'h01);

      start_reset();
      fill_mem(16'h1111);
      end_reset();
      repeat (6) step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_pc", 32'(pc_out), 32'h05);
         check("stall_addr", 32'(imem_addr), 32'h05);
         check("stall_fede", 32'(FEDE_output), 32'h041111);
      end
      stall = 1'b0;
      step();
      check("unstall_fede", 32'(FEDE_output), 32'h051111);
      check("unstall_pc", 32'(pc_out), 32'h06);

      run_branch(4'hA, 1'b1, 1'b0, 1'b1, "bz_z1");
      run_branch(4'hA, 1'b0, 1'b0, 1'b0, "bz_z0");
      run_branch(4'h9, 1'b0, 1'b0, 1'b1, "br");
      run_branch(4'hB, 1'b0, 1'b1, 1'b1, "bn_n1");
      run_branch(4'hB, 1'b1, 1'b0, 1'b0, "bn_n0");
      run_branch(4'hC, 1'b0, 1'b0, 1'b1, "bnz_z0");
      run_branch(4'hC, 1'b1, 1'b1, 1'b0, "bnz_z1");

      start_reset();
      fill_mem(16'h1111);
      mem[0] = 16'h0FFF;
      end_reset();
      repeat (3) step();
      for (int i = 0; i < 10; i++) begin
         check("halt_halted", 32'(halted), 32'h1);
         check("halt_fede", 32'(FEDE_output), 32'h010000);
         check("halt_pc", 32'(pc_out), 32'h01);
         stall   = 1'($urandom);
         Z_input = 1'($urandom);
         N_input = 1'($urandom);
         step();
      end
      reset_input = 1'b0;
      #1;
      check("halt_rst_halted", 32'(halted), 32'h0);
      check("halt_rst_pc", 32'(pc_out), 32'h00);

      start_reset();
      fill_mem(16'h1111);
      mem[0] = 16'h9040;
      end_reset();
      repeat (2) step();
      stall = 1'b1;
      #1;
      check("midbr_stalled_taken", 32'(branch_taken), 32'h0);
      repeat (2) step();
      check("midbr_hold_fede", 32'(FEDE_output), 32'h009040);
      check("midbr_hold_pc", 32'(pc_out), 32'h01);
      #1;
      reset_input = 1'b0;
      #1;
      check("midbr_rst_pc", 32'(pc_out), 32'h00);
      check("midbr_rst_fede", 32'(FEDE_output), 32'h000000);
      check("midbr_rst_taken", 32'(branch_taken), 32'h0);
      check("midbr_rst_halted", 32'(halted), 32'h0);
      stall = 1'b0;
      end_reset();
      step();
      check("midbr_boot_fede", 32'(FEDE_output), 32'h000000);
      step();
      check("midbr_refetch_fede", 32'(FEDE_output), 32'h009040);

      for (int ep = 0; ep < 8; ep++) begin
         start_reset();
         fill_random();
         end_reset();
         for (int cyc = 0; cyc < 250; cyc++) begin
            stall   = ($urandom_range(0, 3) == 0);
            Z_input = 1'($urandom);
            N_input = 1'($urandom);
            if ($urandom_range(0, 149) == 0) begin
               reset_input = 1'b0;
               #2;
               reset_input = 1'b1;
            end
            step();
         end
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
